// File: rtl/pipelined_normalizer.sv
// Two-stage pipelined normalizer between the arithmetic core and the rounder.
// Stage 1 registers the operands and their leading-zero count; stage 2 applies
// the shift, adjusts the exponent and derives the zero/denormal flags.
module pipelined_normalizer #(
  parameter int EXP_W             = 10,
  parameter int FRAC_W            = 49,
  parameter bit GRADUAL_UNDERFLOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_normalize,
  input  logic [EXP_W-1:0]  in_exponent,
  input  logic [FRAC_W-1:0] in_fraction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exponent,
  output logic [FRAC_W-1:0] out_fraction,
  output logic              out_zero,
  output logic              out_denormal
);

  localparam int M     = FRAC_W - 1;
  localparam int SH_W  = $clog2(FRAC_W);
  localparam int CMP_W = EXP_W + SH_W;

  logic              s1_valid;
  logic              s1_norm;
  logic [EXP_W-1:0]  s1_exp;
  logic [FRAC_W-1:0] s1_frac;
  logic [SH_W-1:0]   s1_lz;
  logic [SH_W-1:0]   lz;

  logic              out_advance;
  logic              s1_advance;

  logic [EXP_W-1:0]  n_exp;
  logic [FRAC_W-1:0] n_frac;
  logic              n_zero;
  logic              n_den;
  logic [SH_W-1:0]   shift;
  logic [EXP_W-1:0]  lim;

  // Each stage advances when its successor is empty or draining; bubbles collapse.
  assign out_advance = !out_valid || out_ready;
  assign s1_advance  = s1_valid && out_advance;
  assign in_ready    = !s1_valid || s1_advance;

  // Leading zeros below the overflow bit; the highest set bit wins the scan.
  always_comb begin
    lz = SH_W'(M);
    for (int unsigned i = 0; i < M; i++) begin
      if (in_fraction[i]) lz = SH_W'(M - 1 - i);
    end
  end

  // Stage 1 register: operands plus leading-zero count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_norm  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_lz    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_norm <= in_normalize;
        s1_exp  <= in_exponent;
        s1_frac <= in_fraction;
        s1_lz   <= lz;
      end
    end
  end

  // Stage 2 datapath: case selection in priority order, shift and flags.
  always_comb begin
    n_exp  = s1_exp;
    n_frac = s1_frac;
    n_zero = 1'b0;
    n_den  = 1'b0;
    shift  = s1_lz;
    lim    = s1_exp - EXP_W'(1);
    if (!s1_norm) begin
      n_zero = (s1_frac == '0);
    end else if (s1_frac == '0) begin
      n_exp  = '0;
      n_zero = 1'b1;
    end else if (s1_frac[M]) begin
      n_frac = {1'b0, s1_frac[M:2], s1_frac[1] | s1_frac[0]};
      n_exp  = s1_exp + EXP_W'(1);
    end else if (!s1_frac[M-1]) begin
      // Clamp keeps the exponent at or above 1; a clamped shift leaves a denormal.
      if (GRADUAL_UNDERFLOW) begin
        if ($signed(s1_exp) <= $signed(EXP_W'(1))) shift = '0;
        else if (CMP_W'(lim) < CMP_W'(s1_lz)) shift = SH_W'(lim);
      end
      n_frac = s1_frac << shift;
      n_exp  = s1_exp - EXP_W'(shift);
      n_den  = (shift < s1_lz);
    end
  end

  // Output register: holds while stalled by downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_exponent <= '0;
      out_fraction <= '0;
      out_zero     <= 1'b0;
      out_denormal <= 1'b0;
    end else if (out_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_exponent <= n_exp;
        out_fraction <= n_frac;
        out_zero     <= n_zero;
        out_denormal <= n_den;
      end
    end
  end

endmodule

// File: doc/pipelined_normalizer.md
Name: pipelined_normalizer

Overview:
- Parametrised, pipelined successor to the FPU's combinational normalizer.
- Takes an unnormalised exponent/fraction pair from the add/mul/div datapath and returns a normalised pair with result flags.
- Leading-zero detection covers the full fraction width, not a 32-bit window.
- Adds a sticky bit on right shift, gradual-underflow shift clamping, zero detection and valid/ready flow control.
- Sits between the arithmetic core and the rounder.

Parameters:
- EXP_W, 10, exponent width; two's-complement signed.
- FRAC_W, 49, fraction width; format [xx.xxx…]: 2 integer bits, FRAC_W-2 fraction bits, hidden-bit position FRAC_W-2.
- GRADUAL_UNDERFLOW, 1, when 1 the left shift is clamped so the exponent never goes below 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- in_normalize  in  1  1 = normalise; 0 = pass through.
- in_exponent  in  EXP_W  calculated exponent.
- in_fraction  in  FRAC_W  calculated fraction.
- out_valid  out  1  output transaction present.
- out_ready  in  1  downstream accepts output.
- out_exponent  out  EXP_W  normalised exponent.
- out_fraction  out  FRAC_W  normalised fraction.
- out_zero  out  1  result fraction is all zero.
- out_denormal  out  1  underflow clamp limited the shift; hidden bit not set.

Behaviour:
- Pipeline has 2 register stages.
  - S1: registers the inputs and computes the case and the leading-zero count (lz) over in_fraction[FRAC_W-2:0].
  - S2: shift, exponent update and flags; registered to the outputs.
- Latency is 2 cycles from input handshake to out_valid with no stalls. Throughput is 1 per cycle.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - Each stage advances when the next stage is empty or advancing. Bubbles collapse.
  - in_ready = !s1_valid || s1_advance. The combinational out_ready -> in_ready path is permitted.
  - Output data and flags hold stable while out_valid && !out_ready.
- Reset:
  - All valid bits clear immediately; in-flight data is discarded.
  - out_exponent, out_fraction, out_zero and out_denormal reset to 0.
  - in_ready is 1 from the first cycle after reset deasserts.
- Let F = fraction, E = exponent, M = FRAC_W-1. Cases are evaluated in priority order:
  1. normalize=0: E and F pass unchanged; out_zero=(F==0); out_denormal=0.
  2. F==0: out_fraction=0, out_exponent=0, out_zero=1, out_denormal=0.
  3. F[M]=1 (overflow): out_fraction = {1'b0, F[M:2], F[1]|F[0]} (sticky into bit 0); out_exponent = E+1 (wraps modulo 2^EXP_W, no saturation).
  4. F[M-1]=1: already normalised; pass unchanged.
  5. Otherwise compute the left shift s:
     - GRADUAL_UNDERFLOW=0: s = lz.
     - GRADUAL_UNDERFLOW=1: s = 0 if signed E <= 1, else min(lz, E-1).
     - out_fraction = F << s (zero fill); out_exponent = E - s.
     - out_denormal = (s < lz).
     - With GRADUAL_UNDERFLOW=0, the exponent may go ≤ 0; the rounder handles it.
- lz ranges 1…FRAC_W-2 in case 5. The shift-count width is clog2(FRAC_W).
- No internal state other than the pipeline registers; no X propagation from empty stages.

Test Plan:
- Case 5, normal shift: E=100, F=1<<40, normalize=1 -> after 2 cycles out_exponent=93, out_fraction=1<<47, out_zero=0, out_denormal=0.
- Case 3, overflow with sticky: E=127, F=49'h1_8000_0000_0001 -> out_exponent=128, out_fraction=49'h0_C000_0000_0001.
- Underflow clamp:
  - GRADUAL_UNDERFLOW=1, E=5, F=1<<40 -> out_exponent=1, out_fraction=1<<44, out_denormal=1.
  - GRADUAL_UNDERFLOW=0, same input -> out_exponent=-2 (10'h3FE), out_fraction=1<<47.
- Zero and pass-through:
  - F=0, normalize=1 -> out_zero=1, out_exponent=0.
  - normalize=0, E=7, F=1<<30 -> out_exponent=7, out_fraction=1<<30 unchanged.
- Backpressure: stream 5 transactions back-to-back, hold out_ready=0 for 4 cycles, then release.
  - in_ready drops after 2 accepted.
  - Output holds stable while stalled.
  - All 5 results emerge in order with no loss or duplication.
- Reset mid-stream: assert reset with 2 transactions in flight -> out_valid=0 immediately; no stale result appears after release; the next input emerges 2 cycles after acceptance.
